dcache_mem_initiator: RTL and testbench

Memory-side miss engine of the data cache. It serves line-fill and victim-writeback requests from the dcache controller by driving the 256-bit line interface toward `Data_Memory`. It issues an optional dirty-victim write, then a line read, and returns the fetched line to the cache with its new tag. It is the initiator end of the `enable`/`write`/`ack` memory handshake.

---
 rtl/dcache_pkg.sv | 38 +++
 rtl/mem_ack_watchdog.sv | 48 ++++
 rtl/dcache_mem_initiator.sv | 163 ++++++++++++++++
 tb/tb_dcache_mem_initiator.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_pkg
// Brief    : Shared types, geometry constants and address helpers for dcache.
// Revision : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int ADDR_W    = 32;
    localparam int LINE_W    = 256;
    localparam int TAG_W     = 23;
    localparam int IDX_W     = 4;
    localparam int OFFSET_W  = 5;
    localparam int VALID_BIT = 24;
    localparam int DIRTY_BIT = 23;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITEBACK = 3'd1,
        ST_GAP       = 3'd2,
        ST_ALLOCATE  = 3'd3,
        ST_FILL      = 3'd4
    } state_t;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W+IDX_W-1:OFFSET_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ack_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : mem_ack_watchdog
// Brief    : Saturating wait counter with clear and a sticky timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ack_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_err
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT);

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nx;
    logic               r_err;

    always_comb begin
        w_cnt_nx = r_cnt;
        if (i_clr) begin
            w_cnt_nx = '0;
        end else if (i_en && (r_cnt != c_LIMIT)) begin
            w_cnt_nx = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nx;
            if (w_cnt_nx == c_LIMIT) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_err = r_err;

endmodule
`default_nettype wire

// File: rtl/dcache_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : dcache_mem_initiator
// Brief    : Dcache miss engine: optional victim writeback, then line fill.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_mem_initiator #(
    parameter int ADDR_W  = dcache_pkg::ADDR_W,
    parameter int LINE_W  = dcache_pkg::LINE_W,
    parameter int TAG_W   = dcache_pkg::TAG_W,
    parameter int IDX_W   = dcache_pkg::IDX_W,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              victim_dirty_i,
    input  logic [TAG_W-1:0]  victim_tag_i,
    input  logic [LINE_W-1:0] victim_data_i,
    output logic              busy_o,
    output logic              fill_valid_o,
    output logic [LINE_W-1:0] fill_data_o,
    output logic [TAG_W+1:0]  fill_tag_o,
    output logic              err_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i
);
    import dcache_pkg::*;

    state_t            r_state,      w_state_nx;
    logic              r_busy,       w_busy_nx;
    logic              r_fill_valid, w_fill_valid_nx;
    logic [LINE_W-1:0] r_fill_data,  w_fill_data_nx;
    logic [TAG_W+1:0]  r_fill_tag,   w_fill_tag_nx;
    logic              r_mem_en,     w_mem_en_nx;
    logic              r_mem_wr,     w_mem_wr_nx;
    logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nx;
    logic [LINE_W-1:0] r_mem_data,   w_mem_data_nx;
    logic [ADDR_W-1:0] r_req_addr,   w_req_addr_nx;
    logic              w_wait_en;
    logic              w_wait_clr;

    always_comb begin
        w_state_nx      = r_state;
        w_fill_valid_nx = 1'b0;
        w_fill_data_nx  = r_fill_data;
        w_fill_tag_nx   = r_fill_tag;
        w_mem_en_nx     = r_mem_en;
        w_mem_wr_nx     = r_mem_wr;
        w_mem_addr_nx   = r_mem_addr;
        w_mem_data_nx   = r_mem_data;
        w_req_addr_nx   = r_req_addr;
        case (r_state)
            ST_IDLE: begin
                if (req_i) begin
                    w_req_addr_nx = req_addr_i;
                    w_mem_en_nx   = 1'b1;
                    if (victim_dirty_i) begin
                        w_state_nx    = ST_WRITEBACK;
                        w_mem_wr_nx   = 1'b1;
                        w_mem_addr_nx = {victim_tag_i,
                                         req_addr_i[OFFSET_W+IDX_W-1:OFFSET_W],
                                         {OFFSET_W{1'b0}}};
                        w_mem_data_nx = victim_data_i;
                    end else begin
                        w_state_nx    = ST_ALLOCATE;
                        w_mem_wr_nx   = 1'b0;
                        w_mem_addr_nx = {req_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        w_mem_data_nx = '0;
                    end
                end
            end
            ST_WRITEBACK: begin
                if (mem_ack_i) begin
                    w_state_nx  = ST_GAP;
                    w_mem_en_nx = 1'b0;
                    w_mem_wr_nx = 1'b0;
                end
            end
            ST_GAP: begin
                // Read address comes from the captured request, not the live input.
                w_state_nx    = ST_ALLOCATE;
                w_mem_en_nx   = 1'b1;
                w_mem_wr_nx   = 1'b0;
                w_mem_addr_nx = {r_req_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                w_mem_data_nx = '0;
            end
            ST_ALLOCATE: begin
                if (mem_ack_i) begin
                    w_state_nx      = ST_FILL;
                    w_mem_en_nx     = 1'b0;
                    w_fill_valid_nx = 1'b1;
                    w_fill_data_nx  = mem_data_i;
                    w_fill_tag_nx   = {1'b1, 1'b0, r_req_addr[ADDR_W-1 -: TAG_W]};
                end
            end
            ST_FILL: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx  = ST_IDLE;
                w_mem_en_nx = 1'b0;
                w_mem_wr_nx = 1'b0;
            end
        endcase
        w_busy_nx = (w_state_nx != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_fill_valid <= 1'b0;
            r_fill_data  <= '0;
            r_fill_tag   <= '0;
            r_mem_en     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_req_addr   <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_busy       <= w_busy_nx;
            r_fill_valid <= w_fill_valid_nx;
            r_fill_data  <= w_fill_data_nx;
            r_fill_tag   <= w_fill_tag_nx;
            r_mem_en     <= w_mem_en_nx;
            r_mem_wr     <= w_mem_wr_nx;
            r_mem_addr   <= w_mem_addr_nx;
            r_mem_data   <= w_mem_data_nx;
            r_req_addr   <= w_req_addr_nx;
        end
    end

    assign w_wait_en  = ((r_state == ST_WRITEBACK) || (r_state == ST_ALLOCATE)) && !mem_ack_i;
    assign w_wait_clr = (w_state_nx != r_state);

    mem_ack_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_en    (w_wait_en),
        .i_clr   (w_wait_clr),
        .o_err   (err_o)
    );

    assign busy_o       = r_busy;
    assign fill_valid_o = r_fill_valid;
    assign fill_data_o  = r_fill_data;
    assign fill_tag_o   = r_fill_tag;
    assign mem_enable_o = r_mem_en;
    assign mem_write_o  = r_mem_wr;
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;

endmodule
`default_nettype wire

// File: tb/tb_dcache_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_mem_initiator
// Brief    : Randomized self-checking bench with a 10-cycle memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_mem_initiator;

    localparam int c_LAT = 10;
    localparam int c_TMO = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req;
    logic [31:0]  req_addr;
    logic         vdirty;
    logic [22:0]  vtag;
    logic [255:0] vdata;
    logic         busy, fill_valid, err;
    logic [255:0] fill_data;
    logic [24:0]  fill_tag;
    logic         mem_en, mem_wr, mem_ack;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dcache_mem_initiator #(.TIMEOUT(c_TMO)) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .req_i          (req),
        .req_addr_i     (req_addr),
        .victim_dirty_i (vdirty),
        .victim_tag_i   (vtag),
        .victim_data_i  (vdata),
        .busy_o         (busy),
        .fill_valid_o   (fill_valid),
        .fill_data_o    (fill_data),
        .fill_tag_o     (fill_tag),
        .err_o          (err),
        .mem_enable_o   (mem_en),
        .mem_write_o    (mem_wr),
        .mem_addr_o     (mem_addr),
        .mem_data_o     (mem_wdata),
        .mem_ack_i      (mem_ack),
        .mem_data_i     (mem_rdata)
    );

    typedef struct {
        logic [31:0]  addr;
        logic         wr;
        logic [255:0] data;
        int           gap;
    } txn_t;

    txn_t         txq[$];
    logic [255:0] fillq_d[$];
    logic [24:0]  fillq_t[$];
    int           n_vec = 0;
    int           n_err = 0;
    bit           ack_off = 1'b0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        case (a)
            32'h40:  return {16{16'hECFA}};
            32'h200: return {2{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210}};
            32'h20:  return {64'h8888_9999_AAAA_BBBB, 64'hCCCC_DDDD_EEEE_FFFF,
                             64'h7777_6666_5555_4444, 64'h3333_2222_1111_0000};
            default: return {8{a ^ 32'h5A5A_0F0F}};
        endcase
    endfunction

    function automatic logic [255:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Memory target: acks each request c_LAT cycles after it first sees enable.
    initial begin : mem_model
        int   cnt, low;
        bit   pend, done;
        txn_t t;
        mem_ack = 1'b0; mem_rdata = '0;
        cnt = 0; low = 0; pend = 1'b0; done = 1'b0;
        t = '{addr: '0, wr: 1'b0, data: '0, gap: 0};
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!mem_en) begin
                low++; pend = 1'b0; done = 1'b0;
            end else begin
                if (!pend) begin
                    pend = 1'b1; done = 1'b0; cnt = 0;
                    t.addr = mem_addr; t.wr = mem_wr; t.data = mem_wdata; t.gap = low;
                    low = 0;
                    txq.push_back(t);
                end else begin
                    check("req_stable_addr", {mem_addr, mem_wr}, {t.addr, t.wr});
                    check("req_stable_data", mem_wdata, t.data);
                end
                if (!done && !ack_off) begin
                    cnt++;
                    if (cnt == c_LAT) begin
                        mem_ack   = 1'b1;
                        mem_rdata = t.wr ? rand_line() : mem_line(t.addr);
                        done      = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : fill_mon
        forever begin
            @(negedge clk);
            if (fill_valid) begin
                fillq_d.push_back(fill_data);
                fillq_t.push_back(fill_tag);
            end
        end
    end

    task automatic run_miss(input logic [31:0] a, input bit dirty, input logic [22:0] vt,
                            input logic [255:0] vd, input bit spur,
                            input logic [255:0] exp_fill);
        int lat;
        int n;
        txq.delete(); fillq_d.delete(); fillq_t.delete();
        @(negedge clk);
        req = 1'b1; req_addr = a; vdirty = dirty; vtag = vt; vdata = vd;
        @(negedge clk);
        req = 1'b0; req_addr = $urandom; vdirty = ~dirty; vtag = 23'($urandom); vdata = rand_line();
        check("busy_after_accept", {busy, mem_en}, 2'b11);
        lat = 1;
        while (!fill_valid && lat < 200) begin
            if (spur && lat == 4) req = 1'b1;
            if (spur && lat == 7) req = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) check("fill_wait_expired", 1'b0, 1'b1);
        check("fill_latency", lat, dirty ? (2 * c_LAT + 2) : (c_LAT + 1));
        @(negedge clk);
        check("idle_after_fill", {busy, fill_valid, mem_en}, 3'b000);
        n = dirty ? 2 : 1;
        check("txn_count", txq.size(), n);
        if (txq.size() == n) begin
            if (dirty) begin
                check("wb_addr", txq[0].addr, (32'(vt) << 9) | (a & 32'h0000_01E0));
                check("wb_write", txq[0].wr, 1'b1);
                check("wb_data", txq[0].data, vd);
                check("wb_gap", txq[1].gap, 1);
            end
            check("rd_addr", txq[n-1].addr, a & ~32'h1F);
            check("rd_write", txq[n-1].wr, 1'b0);
        end
        check("fill_count", fillq_d.size(), 1);
        if (fillq_d.size() == 1) begin
            check("fill_data", fillq_d[0], exp_fill);
            check("fill_tag", fillq_t[0], {2'b10, 23'(a >> 9)});
        end
        check("fill_hold", fill_data, exp_fill);
    endtask

    initial begin : watchdog_guard
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin : main
        logic [31:0] a;
        bit          d;
        rst_n = 1'b0; req = 1'b0; req_addr = '0; vdirty = 1'b0; vtag = '0; vdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_fill_valid", fill_valid, 1'b0);
        check("rst_fill_data", fill_data, '0);
        check("rst_fill_tag", fill_tag, '0);
        check("rst_err", err, 1'b0);
        check("rst_mem_ctl", {mem_en, mem_wr}, 2'b00);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_data", mem_wdata, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Spurious ack while idle
        #1 mem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_ack_ignored", {busy, mem_en, fill_valid}, 3'b000);

        run_miss(32'h0000_0040, 1'b0, '0, '0, 1'b0, {16{16'hECFA}});
        run_miss(32'h0000_0200, 1'b1, '0, {32{8'hA5}}, 1'b0,
                 {2{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210}});
        run_miss(32'h0000_0040, 1'b0, '0, '0, 1'b1, {16{16'hECFA}});

        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            d = 1'($urandom_range(0, 1));
            run_miss(a, d, 23'($urandom), rand_line(), 1'($urandom_range(0, 1)),
                     mem_line(a & ~32'h1F));
        end
        check("err_clear_normal", err, 1'b0);

        // Reset in the middle of a writeback
        fillq_d.delete();
        @(negedge clk);
        req = 1'b1; req_addr = 32'h0000_0200; vdirty = 1'b1; vtag = 23'd5; vdata = rand_line();
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_wb", {mem_en, mem_wr, busy, fill_valid}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("rst_no_fill", fillq_d.size(), 0);
        run_miss(32'h0000_0020, 1'b0, '0, '0, 1'b0,
                 {64'h8888_9999_AAAA_BBBB, 64'hCCCC_DDDD_EEEE_FFFF,
                  64'h7777_6666_5555_4444, 64'h3333_2222_1111_0000});

        // Ack timeout
        ack_off = 1'b1;
        @(negedge clk);
        req = 1'b1; req_addr = 32'h0000_0040; vdirty = 1'b0;
        @(negedge clk);
        req = 1'b0;
        repeat (15) @(negedge clk);
        check("err_before_limit", err, 1'b0);
        @(negedge clk);
        check("err_at_limit", {err, mem_en}, 2'b11);
        repeat (30) @(negedge clk);
        check("err_sticky", {err, mem_en, busy}, 3'b111);
        #1 rst_n = 1'b0;
        #1 check("err_cleared_by_rst", {err, mem_en}, 2'b00);
        ack_off = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_miss(32'h0000_0040, 1'b0, '0, '0, 1'b0, {16{16'hECFA}});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
